sdp_async_read_ram_4096x32: RTL and testbench

Simple dual-port RAM, 4096 words x 32 bits.
- One synchronous write port and one independent asynchronous (combinational) read port.
- Used as a register-file-style buffer where read data must be available in the same cycle the address is presented.
- Reset clears per-word valid tracking, so never-written words read as zero, not X.

---
 rtl/sdp_async_read_ram_4096x32.sv | 111 +++++++++++
 tb/tb_sdp_async_read_ram_4096x32.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/sdp_async_read_ram_4096x32.sv
// ---------------------------------------------------------------------------
// sdp_async_read_ram_4096x32
//
// Simple dual-port RAM, 4096 x 32. It has one synchronous write port and one
// combinational read port, for register-file style buffers where read data
// must appear in the same cycle as the address.
//
// Every word has a valid bit. Reset clears the valid bits, so a word that has
// never been written (or not written since the last reset) reads as zero. The
// storage array itself is never cleared; the valid bits mask it.
//
// Optional feature (compile-time macro WRITE_THROUGH_EN):
//   When it is defined and an accepted write targets the address being read,
//   dout shows din in the same cycle (write-through bypass). When it is not
//   defined, dout shows the old contents until the clock edge.
//
// Ports:
//   clk        in   1   clock; writes occur on the rising edge
//   rst_n      in   1   asynchronous active-low reset
//   we         in   1   write enable, sampled on rising clk
//   write_addr in   12  write address
//   din        in   32  write data
//   read_addr  in   12  read address (combinational)
//   dout       out  32  read data, combinational from read_addr
// ---------------------------------------------------------------------------
module sdp_async_read_ram_4096x32 #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4096
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [DATA_WIDTH-1:0] din,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [DATA_WIDTH-1:0] dout
);

  // The address decode below assumes a full power-of-two array.
  if (DEPTH != (1 << ADDR_WIDTH)) begin : g_bad_depth
    $error("DEPTH must equal 2**ADDR_WIDTH");
  end

  // -------------------------------------------------------------------------
  // Reset release.
  // run_q drops as soon as rst_n falls. It rises on the first clk edge after
  // rst_n returns high. Writes are gated by this flag, so reset releases
  // synchronously to clk and no write can slip in while reset is active.
  // -------------------------------------------------------------------------
  logic run_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_q <= 1'b0;
    end else begin
      run_q <= 1'b1;
    end
  end

  logic wr_fire;
  assign wr_fire = we & run_q;

  // -------------------------------------------------------------------------
  // Storage array: no reset, so it can map onto distributed RAM with an
  // asynchronous read.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_fire) begin
      mem_q[write_addr] <= din;
    end
  end

  // -------------------------------------------------------------------------
  // Per-word valid bits.
  // Each bit is set by a write to its word and cleared only by reset.
  // -------------------------------------------------------------------------
  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] valid_d;

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_valid
    assign valid_d[gi] = valid_q[gi] |
                         (wr_fire && (write_addr == ADDR_WIDTH'(gi)));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // -------------------------------------------------------------------------
  // Combinational read.
  // The valid mask means uninitialised array contents can never reach dout.
  // -------------------------------------------------------------------------
  logic [DATA_WIDTH-1:0] rd_word;
  assign rd_word = valid_q[read_addr] ? mem_q[read_addr] : '0;

`ifdef WRITE_THROUGH_EN
  // An in-flight write to the address being read bypasses the array. run_q
  // is low whenever rst_n is low, so no bypass happens during reset.
  assign dout = (wr_fire && (read_addr == write_addr)) ? din : rd_word;
`else
  assign dout = rd_word;
`endif

endmodule

// File: tb/tb_sdp_async_read_ram_4096x32.sv
// ---------------------------------------------------------------------------
// Testbench for sdp_async_read_ram_4096x32.
//
// The stimulus tasks push the expected dout into a queue. A separate monitor
// process pops each entry and compares it against the live dout.
// The reference model is an associative array: a key is present only if
// that address has been written since the last reset.
// ---------------------------------------------------------------------------
module tb_sdp_async_read_ram_4096x32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        we = 1'b0;
  logic [11:0] write_addr = '0;
  logic [31:0] din = '0;
  logic [11:0] read_addr = '0;
  logic [31:0] dout;

  sdp_async_read_ram_4096x32 dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (we),
    .write_addr(write_addr),
    .din       (din),
    .read_addr (read_addr),
    .dout      (dout)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic [11:0] addr;
    logic [31:0] exp;
  } chk_t;

  chk_t        exp_q[$];
  logic [31:0] model [int];
  int          checks = 0;
  int          errors = 0;

  function automatic logic [31:0] ref_rd(input logic [11:0] a);
    if (model.exists(int'(a))) return model[int'(a)];
    return 32'h0;
  endfunction

  // Monitor: compares dout whenever an expectation is presented.
  initial begin
    chk_t it;
    forever begin
      wait (exp_q.size() != 0);
      it = exp_q[0];
      checks++;
      if (dout !== it.exp) begin
        errors++;
        $display("FAIL %s addr=%03h dout=%08h expected=%08h",
                 it.name, it.addr, dout, it.exp);
      end
      void'(exp_q.pop_front());
    end
  end

  // Push one expectation and wait (bounded) for the monitor to consume it.
  task automatic expect_now(input string nm, input logic [11:0] a,
                            input logic [31:0] e);
    chk_t it;
    it.name = nm;
    it.addr = a;
    it.exp  = e;
    exp_q.push_back(it);
    for (int t = 0; t < 4 && exp_q.size() != 0; t++) #0;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL monitor_stall %s queue=%0d required=0", nm, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic do_write(input logic [11:0] wa, input logic [31:0] d,
                          input logic [11:0] ra, input string nm);
    logic [31:0] pre;
    @(negedge clk);
    we = 1'b1;
    write_addr = wa;
    din = d;
    read_addr = ra;
    #1;
`ifdef WRITE_THROUGH_EN
    pre = (ra == wa) ? d : ref_rd(ra);
`else
    pre = ref_rd(ra);
`endif
    expect_now({nm, "_pre"}, ra, pre);
    @(posedge clk);
    model[int'(wa)] = d;
    #1;
    expect_now({nm, "_post"}, ra, ref_rd(ra));
    we = 1'b0;
  endtask

  task automatic do_read(input logic [11:0] ra, input string nm);
    @(negedge clk);
    we = 1'b0;
    read_addr = ra;
    #1;
    expect_now(nm, ra, ref_rd(ra));
  endtask

  // Full reset: assert between edges, hold, release at negedge, then one idle
  // edge so that reset has released before any write.
  task automatic do_reset();
    @(negedge clk);
    we = 1'b0;
    #2 rst_n = 1'b0;
    model.delete();
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] d;
    int          c0;

    #1 rst_n = 1'b0;
    do_reset();

    // 1: every address reads zero after reset.
    c0 = checks;
    for (int a = 0; a < 4096; a++) do_read(12'(a), "t1_zero");
    $display("[%0t] test1 reset sweep: %0d reads", $time, checks - c0);

    // 2: write each address while reading it, then read everything back.
    c0 = checks;
    for (int a = 0; a < 4096; a++) do_write(12'(a), $urandom, 12'(a), "t2_wr");
    for (int a = 0; a < 4096; a++) do_read(12'(a), "t2_rd");
    $display("[%0t] test2 write/readback: %0d checks", $time, checks - c0);

    // 3: after a reset, write every address while reading random addresses.
    do_reset();
    c0 = checks;
    for (int a = 0; a < 4096; a++)
      do_write(12'(a), $urandom, 12'($urandom_range(0, 4095)), "t3_wr");
    for (int a = 0; a < 4096; a++) do_read(12'(a), "t3_rd");
    $display("[%0t] test3 random read during write: %0d checks", $time, checks - c0);

    // 4: overwrite the same word; its neighbour was never written.
    do_reset();
    do_write(12'hABC, 32'hDEADBEEF, 12'hABC, "t4_wr1");
    $display("[%0t] test4 write abc=deadbeef", $time);
    do_write(12'hABC, 32'h12345678, 12'hABB, "t4_wr2");
    $display("[%0t] test4 write abc=12345678", $time);
    do_read(12'hABC, "t4_rd_abc");
    expect_now("t4_abc_const", 12'hABC, 32'h12345678);
    $display("[%0t] test4 read abc dout=%08h", $time, dout);
    do_read(12'hABB, "t4_rd_abb");
    expect_now("t4_abb_const", 12'hABB, 32'h0);
    $display("[%0t] test4 read abb dout=%08h", $time, dout);

    // 5: reset asserted mid-operation.
    do_write(12'h001, 32'hCAFEF00D, 12'h001, "t5_wr");
    do_read(12'h001, "t5_rd_before");
    $display("[%0t] test5 pre-reset read 001 dout=%08h", $time, dout);
    #2 rst_n = 1'b0;
    model.delete();
    #1 expect_now("t5_async_clear", 12'h001, 32'h0);
    $display("[%0t] test5 rst_n low, read 001 dout=%08h", $time, dout);
    we = 1'b1;
    write_addr = 12'h001;
    din = 32'h0BADBEEF;
    #1 expect_now("t5_no_bypass_in_rst", 12'h001, 32'h0);
    @(posedge clk);
    #1 expect_now("t5_write_in_rst", 12'h001, 32'h0);
    $display("[%0t] test5 write during reset, dout=%08h", $time, dout);
    @(negedge clk);
    we = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1 expect_now("t5_after_release", 12'h001, 32'h0);
    do_write(12'h001, 32'h00000055, 12'h001, "t5_new");
    do_read(12'h001, "t5_rd_new");
    expect_now("t5_new_const", 12'h001, 32'h00000055);
    $display("[%0t] test5 after release read 001 dout=%08h", $time, dout);

    // 6: boundary addresses and their neighbours.
    do_write(12'hFFF, 32'hFFFFFFFF, 12'hFFE, "t6_wr_fff");
    do_write(12'h000, 32'h00000001, 12'hFFF, "t6_wr_000");
    do_read(12'hFFF, "t6_rd_fff");
    expect_now("t6_fff_const", 12'hFFF, 32'hFFFFFFFF);
    do_read(12'h000, "t6_rd_000");
    expect_now("t6_000_const", 12'h000, 32'h00000001);
    do_read(12'hFFE, "t6_rd_ffe");
    expect_now("t6_ffe_const", 12'hFFE, 32'h0);
    do_read(12'h001, "t6_rd_001");
    expect_now("t6_001_const", 12'h001, 32'h00000055);
    $display("[%0t] test6 boundaries checked, 001 dout=%08h", $time, dout);

    // Short random mix of writes and reads.
    c0 = checks;
    for (int i = 0; i < 200; i++) begin
      d = $urandom;
      if (d[0]) do_write(12'($urandom_range(0, 15)), $urandom,
                         12'($urandom_range(0, 15)), "mix_wr");
      else      do_read(12'($urandom_range(0, 15)), "mix_rd");
    end
    $display("[%0t] random mix: %0d checks", $time, checks - c0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
